// File: rtl/pc_unit_pkg.sv
// Shared CPU definitions: the address type and the program-counter defaults
// that the jump unit and the control ROM must agree on.
`default_nettype none

package pc_unit_pkg;

  typedef logic [15:0] pc_t;

  localparam pc_t DEFAULT_RESET_VEC = 16'h0000;
  localparam int  DEFAULT_DEPTH     = 4;

endpackage

`default_nettype wire

// File: rtl/pc_unit_ret_stack.sv
// ret_stack: DEPTH-entry LIFO of return addresses. Push writes at index sp,
// and the top entry is index sp-1. Push/pop are ignored when full/empty.
`default_nettype none

module ret_stack
  import pc_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  pc_t                          din,
  output pc_t                          top,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] ONE      = SPW'(1);
  localparam logic [SPW-1:0] FULL_CNT = SPW'(DEPTH);

  pc_t            mem [DEPTH];
  logic [SPW-1:0] top_idx;

  assign full    = (sp == FULL_CNT);
  assign empty   = (sp == '0);
  assign top_idx = sp - ONE;
  // Reading with sp=0 yields a stale entry; the caller never uses it then.
  assign top     = mem[top_idx[IW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + ONE;
    end else if (pop && !empty) begin
      sp <= sp - ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// pc_unit: program counter with advance, jump, and call/return through a
// small hardware return-address stack. Priority is ret > pcoe > inc > hold.
`default_nettype none

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int  DEPTH     = DEFAULT_DEPTH,
  parameter pc_t RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  input  logic                         pcoe,
  input  pc_t                          pcjmp,
  input  logic                         call,
  input  logic                         ret,
  output pc_t                          pc,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         ovf,
  output logic                         unf
);

  pc_t  stack_top;
  logic stack_full;
  logic stack_empty;
  logic do_push;
  logic do_pop;
  logic set_ovf;
  logic set_unf;
  pc_t  pc_next;

  // A taken call pushes the current pc, which already points past the operands.
  assign do_push = !ret && pcoe && call && !stack_full;
  assign do_pop  = ret && !stack_empty;
  assign set_ovf = !ret && pcoe && call && stack_full;
  assign set_unf = ret && stack_empty;

  always_comb begin
    pc_next = pc;
    if (ret) begin
      if (!stack_empty) begin
        pc_next = stack_top;
      end
    end else if (pcoe) begin
      pc_next = pcjmp;
    end else if (inc) begin
      pc_next = pc + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc  <= RESET_VEC;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      pc  <= pc_next;
      ovf <= ovf | set_ovf;
      unf <= unf | set_unf;
    end
  end

  ret_stack #(
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .din   (pc),
    .top   (stack_top),
    .sp    (sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit with DEPTH=4, plus hand-written
// sequences for sticky underflow and asynchronous reset mid-operation.
`default_nettype none

module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        inc;
  logic        pcoe;
  logic [15:0] pcjmp;
  logic        call;
  logic        ret;
  logic [15:0] pc;
  logic [2:0]  sp;
  logic        ovf;
  logic        unf;

  int checks;
  int failures;

  pc_unit #(
    .DEPTH     (4),
    .RESET_VEC (16'h0000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .pcoe  (pcoe),
    .pcjmp (pcjmp),
    .call  (call),
    .ret   (ret),
    .pc    (pc),
    .sp    (sp),
    .ovf   (ovf),
    .unf   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        inc;
    logic        pcoe;
    logic        call;
    logic        ret;
    logic [15:0] pcjmp;
    logic [15:0] exp_pc;
    logic [2:0]  exp_sp;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [15:0] e_pc,
                       input logic [2:0] e_sp, input logic e_ovf, input logic e_unf);
    checks++;
    if (pc !== e_pc) begin
      failures++;
      $display("FAIL %s pc: got %h expected %h", name, pc, e_pc);
    end
    checks++;
    if (sp !== e_sp) begin
      failures++;
      $display("FAIL %s sp: got %0d expected %0d", name, sp, e_sp);
    end
    checks++;
    if (ovf !== e_ovf) begin
      failures++;
      $display("FAIL %s ovf: got %b expected %b", name, ovf, e_ovf);
    end
    checks++;
    if (unf !== e_unf) begin
      failures++;
      $display("FAIL %s unf: got %b expected %b", name, unf, e_unf);
    end
  endtask

  task automatic step(input logic i, input logic p, input logic c, input logic r,
                      input logic [15:0] j);
    inc   = i;
    pcoe  = p;
    call  = c;
    ret   = r;
    pcjmp = j;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic i, input logic p, input logic c,
                     input logic r, input logic [15:0] j, input logic [15:0] epc,
                     input logic [2:0] esp, input logic eo, input logic eu);
    vec_t v;
    v.name = n; v.inc = i; v.pcoe = p; v.call = c; v.ret = r; v.pcjmp = j;
    v.exp_pc = epc; v.exp_sp = esp; v.exp_ovf = eo; v.exp_unf = eu;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b0;
    inc   = 1'b0;
    pcoe  = 1'b0;
    call  = 1'b0;
    ret   = 1'b0;
    pcjmp = 16'h0000;

    //   name         inc pcoe call ret  pcjmp     pc       sp   ovf  unf
    add("inc1",        1,  0,   0,  0, 16'h0000, 16'h0001, 3'd0, 0, 0);
    add("inc2",        1,  0,   0,  0, 16'h0000, 16'h0002, 3'd0, 0, 0);
    add("inc3",        1,  0,   0,  0, 16'h0000, 16'h0003, 3'd0, 0, 0);
    add("jmp_ffff",    0,  1,   0,  0, 16'hFFFF, 16'hFFFF, 3'd0, 0, 0);
    add("wrap",        1,  0,   0,  0, 16'h0000, 16'h0000, 3'd0, 0, 0);
    add("jmp_0010",    0,  1,   0,  0, 16'h0010, 16'h0010, 3'd0, 0, 0);
    add("jmp_over_inc",1,  1,   0,  0, 16'h1234, 16'h1234, 3'd0, 0, 0);
    add("jmp_0010b",   0,  1,   0,  0, 16'h0010, 16'h0010, 3'd0, 0, 0);
    add("call_nottaken",1, 0,   1,  0, 16'h1234, 16'h0011, 3'd0, 0, 0);
    add("jmp_0020",    0,  1,   0,  0, 16'h0020, 16'h0020, 3'd0, 0, 0);
    add("call_0400",   0,  1,   1,  0, 16'h0400, 16'h0400, 3'd1, 0, 0);
    add("ret_0020",    0,  0,   0,  1, 16'h0000, 16'h0020, 3'd0, 0, 0);
    add("jmp_0100",    0,  1,   0,  0, 16'h0100, 16'h0100, 3'd0, 0, 0);
    add("call1",       0,  1,   1,  0, 16'h0200, 16'h0200, 3'd1, 0, 0);
    add("call2",       0,  1,   1,  0, 16'h0300, 16'h0300, 3'd2, 0, 0);
    add("call3",       0,  1,   1,  0, 16'h0400, 16'h0400, 3'd3, 0, 0);
    add("call4",       1,  1,   1,  0, 16'h0500, 16'h0500, 3'd4, 0, 0);
    add("call5_ovf",   0,  1,   1,  0, 16'h0600, 16'h0600, 3'd4, 1, 0);
    add("ret1_prio",   1,  1,   1,  1, 16'h0BAD, 16'h0400, 3'd3, 1, 0);
    add("ret2",        0,  0,   0,  1, 16'h0000, 16'h0300, 3'd2, 1, 0);
    add("ret3",        0,  0,   0,  1, 16'h0000, 16'h0200, 3'd1, 1, 0);
    add("ret4",        0,  0,   0,  1, 16'h0000, 16'h0100, 3'd0, 1, 0);
    add("jmp_0033",    0,  1,   0,  0, 16'h0033, 16'h0033, 3'd0, 1, 0);
    add("ret_unf",     1,  1,   1,  1, 16'h0BAD, 16'h0033, 3'd0, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("hold_after_reset", 16'h0000, 3'd0, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      step(vecs[k].inc, vecs[k].pcoe, vecs[k].call, vecs[k].ret, vecs[k].pcjmp);
      check(vecs[k].name, vecs[k].exp_pc, vecs[k].exp_sp, vecs[k].exp_ovf, vecs[k].exp_unf);
    end

    // Sticky flags survive normal activity.
    for (int n = 1; n <= 10; n++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      check($sformatf("sticky%0d", n), 16'h0033 + 16'(n), 3'd0, 1'b1, 1'b1);
    end

    // Build sp=2, pc=0777, then reset asynchronously between edges.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0200);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0777);
    check("pre_async", 16'h0777, 3'd2, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("inc_after_reset", 16'h0001, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("ret_empty_again", 16'h0001, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("hold", 16'h0001, 3'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
